// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures retired {pc, ir} pairs from write-back into a
// first-word-fall-through FIFO, with selectable drop-newest / overwrite-oldest overflow.
module commit_trace_buffer #(
  parameter int              DW     = 32,
  parameter int              DEPTH  = 16,
  parameter int              LIMIT  = 1200,
  parameter int              MODE   = 0,
  parameter logic [DW-1:0]   BUBBLE = DW'(32'hffffffff)
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       cap_en,
  input  logic [DW-1:0]              wb_pc,
  input  logic [DW-1:0]              wb_ir,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [2*DW-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       full,
  output logic                       empty,
  output logic [31:0]                ret_cnt,
  output logic [15:0]                drop_cnt,
  output logic                       overflow,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam bit OVERWRITE = (MODE == 1);

  logic [2*DW-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic commit;
  logic pop;
  logic lost;
  logic write;

  assign empty    = (occupancy == '0);
  assign full     = (occupancy == (AW+1)'(DEPTH));
  assign rd_valid = !empty;
  assign rd_data  = mem[rd_ptr];
  assign done     = (ret_cnt == 32'(LIMIT));

  assign commit = cap_en && (wb_ir != BUBBLE) && !done && !clear;
  assign pop    = rd_ready && rd_valid && !clear;
  // A commit into a full buffer with no pop loses one entry: the new one in
  // drop mode, the oldest one in overwrite mode.
  assign lost   = commit && full && !pop;
  assign write  = commit && (!full || pop || OVERWRITE);

  // NOTE: the trace storage has no reset; pointers and occupancy alone decide
  // what is valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk_in) begin
    if (write) mem[wr_ptr] <= {wb_pc, wb_ir};
  end

  // NOTE: all sequential state uses non-blocking assignments so every update
  // below sees the pre-edge values of its neighbours.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (write) wr_ptr <= wr_ptr + 1'b1;
      if (pop || (lost && OVERWRITE)) rd_ptr <= rd_ptr + 1'b1;
      if (commit && !pop && !full)    occupancy <= occupancy + 1'b1;
      else if (pop && !commit)        occupancy <= occupancy - 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      ret_cnt  <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      ret_cnt  <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      // commit already excludes done, so ret_cnt cannot pass LIMIT
      if (commit) ret_cnt <= ret_cnt + 32'd1;
      if (lost) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hffff) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench: three buffer configurations share one stimulus stream and
// are compared against a queue-based model, plus directed tables and sequences.
module tb_commit_trace_buffer;

  localparam int N = 3;
  localparam int DEP [N] = '{4, 4, 8};
  localparam int MD  [N] = '{0, 1, 0};
  localparam int LIM [N] = '{1200, 1200, 5};
  localparam logic [31:0] BUB = 32'hffffffff;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        clear;
  logic        cap_en;
  logic [31:0] wb_pc;
  logic [31:0] wb_ir;
  logic        rd_ready;

  logic        rd_valid_o [N];
  logic [63:0] rd_data_o  [N];
  logic        full_o     [N];
  logic        empty_o    [N];
  logic [31:0] ret_o      [N];
  logic [15:0] drop_o     [N];
  logic        ovf_o      [N];
  logic        done_o     [N];
  logic [2:0]  occ_a;
  logic [2:0]  occ_b;
  logic [3:0]  occ_c;

  int errors = 0;
  int checks = 0;

  logic [63:0] mq [N][$];
  int          ret_m  [N];
  int          drop_m [N];
  bit          ovf_m  [N];

  always #5 clk_in = ~clk_in;

  commit_trace_buffer #(.DW(32), .DEPTH(4), .LIMIT(1200), .MODE(0)) u_a (
    .clk_in(clk_in), .reset(reset), .clear(clear), .cap_en(cap_en), .wb_pc(wb_pc),
    .wb_ir(wb_ir), .rd_ready(rd_ready), .rd_valid(rd_valid_o[0]), .rd_data(rd_data_o[0]),
    .occupancy(occ_a), .full(full_o[0]), .empty(empty_o[0]), .ret_cnt(ret_o[0]),
    .drop_cnt(drop_o[0]), .overflow(ovf_o[0]), .done(done_o[0]));

  commit_trace_buffer #(.DW(32), .DEPTH(4), .LIMIT(1200), .MODE(1)) u_b (
    .clk_in(clk_in), .reset(reset), .clear(clear), .cap_en(cap_en), .wb_pc(wb_pc),
    .wb_ir(wb_ir), .rd_ready(rd_ready), .rd_valid(rd_valid_o[1]), .rd_data(rd_data_o[1]),
    .occupancy(occ_b), .full(full_o[1]), .empty(empty_o[1]), .ret_cnt(ret_o[1]),
    .drop_cnt(drop_o[1]), .overflow(ovf_o[1]), .done(done_o[1]));

  commit_trace_buffer #(.DW(32), .DEPTH(8), .LIMIT(5), .MODE(0)) u_c (
    .clk_in(clk_in), .reset(reset), .clear(clear), .cap_en(cap_en), .wb_pc(wb_pc),
    .wb_ir(wb_ir), .rd_ready(rd_ready), .rd_valid(rd_valid_o[2]), .rd_data(rd_data_o[2]),
    .occupancy(occ_c), .full(full_o[2]), .empty(empty_o[2]), .ret_cnt(ret_o[2]),
    .drop_cnt(drop_o[2]), .overflow(ovf_o[2]), .done(done_o[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int occ_of(input int k);
    case (k)
      0:       return int'(occ_a);
      1:       return int'(occ_b);
      default: return int'(occ_c);
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mq[k].delete();
      ret_m[k]  = 0;
      drop_m[k] = 0;
      ovf_m[k]  = 1'b0;
    end
  endtask

  // Behavioural model: a queue per buffer; a pop takes the front, a commit
  // appends and, when there is no room, loses either itself or the front.
  task automatic model_update();
    if (reset || clear) begin
      model_reset();
      return;
    end
    for (int k = 0; k < N; k++) begin
      bit pop = rd_ready && (mq[k].size() > 0);
      bit com = cap_en && (wb_ir != BUB) && (ret_m[k] != LIM[k]);
      if (pop) void'(mq[k].pop_front());
      if (com) begin
        ret_m[k]++;
        if (mq[k].size() < DEP[k]) begin
          mq[k].push_back({wb_pc, wb_ir});
        end else begin
          if (MD[k] == 1) begin
            void'(mq[k].pop_front());
            mq[k].push_back({wb_pc, wb_ir});
          end
          ovf_m[k] = 1'b1;
          if (drop_m[k] < 65535) drop_m[k]++;
        end
      end
    end
  endtask

  task automatic model_compare();
    for (int k = 0; k < N; k++) begin
      int sz = mq[k].size();
      check($sformatf("m%0d rd_valid", k), 64'(rd_valid_o[k]), 64'(sz > 0));
      if (sz > 0) check($sformatf("m%0d rd_data", k), rd_data_o[k], mq[k][0]);
      check($sformatf("m%0d occupancy", k), 64'(occ_of(k)), 64'(sz));
      check($sformatf("m%0d full", k), 64'(full_o[k]), 64'(sz == DEP[k]));
      check($sformatf("m%0d empty", k), 64'(empty_o[k]), 64'(sz == 0));
      check($sformatf("m%0d ret_cnt", k), 64'(ret_o[k]), 64'(ret_m[k]));
      check($sformatf("m%0d drop_cnt", k), 64'(drop_o[k]), 64'(drop_m[k]));
      check($sformatf("m%0d overflow", k), 64'(ovf_o[k]), 64'(ovf_m[k]));
      check($sformatf("m%0d done", k), 64'(done_o[k]), 64'(ret_m[k] == LIM[k]));
    end
  endtask

  // Inputs are driven at the falling edge; step advances one rising edge and
  // compares at the following falling edge.
  task automatic step();
    @(posedge clk_in);
    model_update();
    @(negedge clk_in);
    model_compare();
  endtask

  task automatic drive(input logic cap, input logic [31:0] pc, input logic [31:0] ir,
                       input logic rdy, input logic clr);
    cap_en   = cap;
    wb_pc    = pc;
    wb_ir    = ir;
    rd_ready = rdy;
    clear    = clr;
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s%0d occupancy", tag, k), 64'(occ_of(k)), 64'd0);
      check($sformatf("%s%0d empty", tag, k), 64'(empty_o[k]), 64'd1);
      check($sformatf("%s%0d full", tag, k), 64'(full_o[k]), 64'd0);
      check($sformatf("%s%0d rd_valid", tag, k), 64'(rd_valid_o[k]), 64'd0);
      check($sformatf("%s%0d ret_cnt", tag, k), 64'(ret_o[k]), 64'd0);
      check($sformatf("%s%0d drop_cnt", tag, k), 64'(drop_o[k]), 64'd0);
      check($sformatf("%s%0d overflow", tag, k), 64'(ovf_o[k]), 64'd0);
      check($sformatf("%s%0d done", tag, k), 64'(done_o[k]), 64'd0);
    end
  endtask

  typedef struct {
    logic        cap;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        rdy;
    int          occ;
    logic        valid;
    logic [31:0] head_pc;
    int          ret;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // Expected values for the drop-mode, depth-4 buffer (u_a).
    vecs[0] = '{1'b1, 32'h0,  32'h20080001, 1'b0, 1, 1'b1, 32'h0,  1};
    vecs[1] = '{1'b1, 32'h4,  32'h20080002, 1'b0, 2, 1'b1, 32'h0,  2};
    vecs[2] = '{1'b1, 32'h8,  32'h20080003, 1'b0, 3, 1'b1, 32'h0,  3};
    vecs[3] = '{1'b0, 32'h0,  32'h0,        1'b1, 2, 1'b1, 32'h4,  3};
    vecs[4] = '{1'b0, 32'h0,  32'h0,        1'b1, 1, 1'b1, 32'h8,  3};
    vecs[5] = '{1'b0, 32'h0,  32'h0,        1'b1, 0, 1'b0, 32'h0,  3};
    vecs[6] = '{1'b1, 32'hc,  BUB,          1'b0, 0, 1'b0, 32'h0,  3};
    vecs[7] = '{1'b1, 32'h10, 32'h20080004, 1'b0, 1, 1'b1, 32'h10, 4};
    vecs[8] = '{1'b1, 32'h14, BUB,          1'b0, 1, 1'b1, 32'h10, 4};
    vecs[9] = '{1'b0, 32'h0,  32'h0,        1'b1, 0, 1'b0, 32'h0,  4};

    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk_in);
    model_reset();
    check_reset_state("rst");
    reset = 1'b0;

    // Ordered capture, draining, and bubble filtering.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].cap, vecs[i].pc, vecs[i].ir, vecs[i].rdy, 1'b0);
      step();
      check($sformatf("vec%0d occupancy", i), 64'(occ_a), 64'(vecs[i].occ));
      check($sformatf("vec%0d rd_valid", i), 64'(rd_valid_o[0]), 64'(vecs[i].valid));
      if (vecs[i].valid) check($sformatf("vec%0d head_pc", i), 64'(rd_data_o[0][63:32]), 64'(vecs[i].head_pc));
      check($sformatf("vec%0d ret_cnt", i), 64'(ret_o[0]), 64'(vecs[i].ret));
    end

    // Six pushes without reads: overflow behaviour and the capture limit.
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'(4 * i), 32'h20080000 + 32'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("ovf drop a", 64'(drop_o[0]), 64'd2);
    check("ovf flag a", 64'(ovf_o[0]), 64'd1);
    check("ovf full a", 64'(full_o[0]), 64'd1);
    check("ovf drop b", 64'(drop_o[1]), 64'd2);
    check("ovf occ b", 64'(occ_b), 64'd4);
    check("lim ret c", 64'(ret_o[2]), 64'd5);
    check("lim done c", 64'(done_o[2]), 64'd1);
    check("lim occ c", 64'(occ_c), 64'd5);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf head a%0d", i), 64'(rd_data_o[0][63:32]), 64'(4 * i));
      check($sformatf("ovf head b%0d", i), 64'(rd_data_o[1][63:32]), 64'(8 + 4 * i));
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
    end

    // Asynchronous reset between clock edges.
    drive(1'b1, 32'h40, 32'h20080040, 1'b0, 1'b0);
    step();
    #2 reset = 1'b1;
    #1 check_reset_state("arst");
    step();
    reset = 1'b0;

    // Full buffer with simultaneous push and pop across pointer wrap.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 32'h20080100 + 32'(i), 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(16 + 4 * i), 32'h20080200 + 32'(i), 1'b1, 1'b0);
      step();
      check($sformatf("wrap occ a%0d", i), 64'(occ_a), 64'd4);
      check($sformatf("wrap drop a%0d", i), 64'(drop_o[0]), 64'd0);
      check($sformatf("wrap head a%0d", i), 64'(rd_data_o[0][63:32]), 64'(4 * (i + 1)));
      check($sformatf("wrap head b%0d", i), 64'(rd_data_o[1][63:32]), 64'(4 * (i + 1)));
    end

    // Random traffic against the model, with occasional clears and one reset.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ir;
      ir = ($urandom_range(0, 4) == 0) ? BUB : $urandom;
      drive(($urandom_range(0, 3) != 0), $urandom, ir, $urandom_range(0, 1) == 1,
            $urandom_range(0, 39) == 0);
      if (i == 200) begin
        #2 reset = 1'b1;
        #1 check_reset_state("rrst");
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 Parameter DW, default 32, width of the commit PC and the instruction word.
REQ-002 Parameter DEPTH, default 16, number of trace entries; power of two, minimum 2.
REQ-003 Parameter LIMIT, default 1200, number of retired instructions after which capture stops.
REQ-004 Parameter MODE, default 0, overflow policy: 0 = drop newest, 1 = overwrite oldest.
REQ-005 Parameter BUBBLE, default 32'hffffffff, instruction encoding treated as a pipeline bubble.
REQ-006 Single clock. Reset is asynchronous and active-high.
REQ-007 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 clear  input  1  synchronous clear of all state.
REQ-010 cap_en  input  1  capture enable.
REQ-011 wb_pc  input  DW  PC of the instruction leaving the write-back stage.
REQ-012 wb_ir  input  DW  instruction word leaving the write-back stage.
REQ-013 rd_ready  input  1  consumer accepts the head entry.
REQ-014 rd_valid  output  1  head entry available; equals !empty.
REQ-015 rd_data  output  2*DW  head entry as {pc, ir}; first-word-fall-through.
REQ-016 occupancy  output  clog2(DEPTH)+1  number of stored entries.
REQ-017 full, empty  output  1 each  occupancy==DEPTH, occupancy==0.
REQ-018 ret_cnt  output  32  count of retired (non-bubble, enabled) commits, saturating at LIMIT.
REQ-019 drop_cnt  output  16  count of entries lost to overflow, saturating at 16'hffff.
REQ-020 overflow  output  1  sticky flag; set on the first lost entry.
REQ-021 done  output  1  high when ret_cnt==LIMIT.

Function
REQ-022 A commit is defined as cap_en & (wb_ir != BUBBLE) & !done & !clear.
REQ-023 Each commit increments ret_cnt by 1 and attempts a push of {wb_pc, wb_ir}.
REQ-024 Each pop (rd_ready & rd_valid) advances the read pointer; the next entry appears on rd_data in the following cycle.
REQ-025 Push with !full is written at the write pointer; occupancy +1, or unchanged on a simultaneous pop.
REQ-026 Push while full with a simultaneous pop is accepted in both modes; occupancy stays DEPTH and nothing is lost.
REQ-027 MODE 0, push while full with no pop: entry discarded; drop_cnt +1; overflow set; pointers unchanged.
REQ-028 MODE 1, push while full with no pop: oldest entry overwritten; both pointers advance; occupancy stays DEPTH; drop_cnt +1; overflow set.
REQ-029 Pointers are clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-030 A pop while empty has no effect.
REQ-031 done is asserted combinationally from ret_cnt==LIMIT; a commit in the same cycle that ret_cnt reaches LIMIT-1→LIMIT is still captured.
REQ-032 After done, commits are ignored while reads continue normally.
REQ-033 Capture latency is one cycle: an entry pushed into an empty buffer at edge N gives rd_valid=1 after edge N.
REQ-034 clear has priority over push and pop; pops are blocked during clear.

Reset
REQ-035 Asynchronous reset, and synchronous clear, set both pointers, occupancy, ret_cnt and drop_cnt to 0, and set overflow to 0.
REQ-036 During reset: empty=1, full=0, rd_valid=0, done=0 (for LIMIT>0).
REQ-037 rd_data is don't-care while empty; storage array is not reset.
REQ-038 Reset asserted mid-operation discards all entries immediately; capture resumes on the first edge after deassertion.

Verification
REQ-039 Push 3 commits (pc 0x0,0x4,0x8; ir 0x20080001..3) with rd_ready=0, then hold rd_ready=1 -> entries appear in order; occupancy goes 3,2,1,0; ret_cnt=3.
REQ-040 Interleave wb_ir=32'hffffffff with valid commits -> bubbles are never stored and ret_cnt counts valid commits only.
REQ-041 MODE 0, DEPTH 4: 6 pushes, no reads -> pcs 0x0–0xC retained; drop_cnt=2; overflow=1.
REQ-042 MODE 1, DEPTH 4: 6 pushes, no reads -> pcs 0x8–0x14 retained; drop_cnt=2; occupancy=4.
REQ-043 Full buffer with push and pop in the same cycle for 10 cycles -> occupancy stays 4; drop_cnt=0; FIFO order preserved across pointer wrap.
REQ-044 LIMIT=5: 8 commits -> ret_cnt=5; done=1; 5 entries stored; assert reset mid-stream -> all counters and flags return to 0 asynchronously.
